// File: rtl/volume_ramp_ctrl.sv
// volume_ramp_ctrl: drives the 4-bit gain word of the volume multiplier.
// Raw inc/dec buttons are synchronized, debounced and edge-detected into a
// saturating target level. The applied gain (control) walks toward the
// effective target (0 while muted) one step per RAMP_TICKS sample strobes,
// so the gain only ever changes by one level at a time and never mid-sample.
//
// Optional feature macro: VOL_AUTOREPEAT_EN (hold-to-repeat on a held button).
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   inc_dec      raw buttons, asynchronous: 2'b10 = inc, 2'b01 = dec
//   sample_tick  one-cycle strobe per audio sample
//   mute         1 = ramp gain to 0, 0 = ramp back to target (clk domain)
//   control      applied gain to the multiplier (registered)
//   target       requested level (registered)
//   ramping      1 while control != effective target (registered)
module volume_ramp_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MAX_LEVEL       = 8,
  parameter int unsigned RESET_LEVEL     = 0,
  parameter int unsigned RAMP_TICKS      = 4
`ifdef VOL_AUTOREPEAT_EN
  ,
  parameter int unsigned HOLD_CYCLES     = 12500000,
  parameter int unsigned REPEAT_CYCLES   = 2500000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] inc_dec,
  input  logic       sample_tick,
  input  logic       mute,
  output logic [3:0] control,
  output logic [3:0] target,
  output logic       ramping
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TickW = $clog2(RAMP_TICKS + 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(RAMP_TICKS - 1);
  localparam logic [3:0]       MaxLvl   = 4'(MAX_LEVEL);
  localparam logic [3:0]       RstLvl   = 4'(RESET_LEVEL);

  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

  logic [1:0]       sync1_q, sync2_q, last_q, stable_q, stable_prev_q;
  logic [DebW-1:0]  deb_cnt_q;
  logic [TickW-1:0] tick_q, tick_d;
  logic [3:0]       control_q, control_d, target_q, target_d, eff, eff_d;
  state_e           state_q, state_d;
  logic             inc_evt, dec_evt;

`ifdef VOL_AUTOREPEAT_EN
  localparam int unsigned RepMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RepW = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] HoldLast = RepW'(HOLD_CYCLES - 1);
  localparam logic [RepW-1:0] RepLast  = RepW'(REPEAT_CYCLES - 1);

  logic [RepW-1:0] rep_cnt_q;
  logic            rep_first_q, held, rep_fire;

  // A press counts as held only after its edge event has been consumed.
  assign held     = ((stable_q == 2'b10) || (stable_q == 2'b01)) && (stable_prev_q == stable_q);
  assign rep_fire = held && (rep_first_q ? (rep_cnt_q == HoldLast) : (rep_cnt_q == RepLast));

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (!held || rep_fire) begin
      rep_cnt_q   <= '0;
      rep_first_q <= !held;
    end else begin
      rep_cnt_q   <= rep_cnt_q + 1'b1;
    end
  end
`endif

  // Edge events only leave 00; 11 and any code reached from 11 stay silent.
  always_comb begin
    inc_evt = (stable_prev_q == 2'b00) && (stable_q == 2'b10);
    dec_evt = (stable_prev_q == 2'b00) && (stable_q == 2'b01);
`ifdef VOL_AUTOREPEAT_EN
    inc_evt = inc_evt || (rep_fire && (stable_q == 2'b10));
    dec_evt = dec_evt || (rep_fire && (stable_q == 2'b01));
`endif
  end

  always_comb begin
    target_d = target_q;
    if (inc_evt && (target_q < MaxLvl)) begin
      target_d = target_q + 4'd1;
    end else if (dec_evt && (target_q != 4'd0)) begin
      target_d = target_q - 4'd1;
    end
  end

  assign eff   = mute ? 4'd0 : target_q;
  assign eff_d = mute ? 4'd0 : target_d;

  // Direction comes from the live compare, so a reversal keeps the tick count.
  always_comb begin
    control_d = control_q;
    tick_d    = tick_q;
    if (control_q == eff) begin
      tick_d = '0;
    end else if (sample_tick) begin
      if (tick_q == TickLast) begin
        tick_d    = '0;
        control_d = (control_q < eff) ? control_q + 4'd1 : control_q - 4'd1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_comb begin
    if (control_d < eff_d) begin
      state_d = StUp;
    end else if (control_d > eff_d) begin
      state_d = StDown;
    end else begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 2'b00;
      sync2_q       <= 2'b00;
      last_q        <= 2'b00;
      stable_q      <= 2'b00;
      stable_prev_q <= 2'b00;
      deb_cnt_q     <= '0;
      tick_q        <= '0;
      control_q     <= RstLvl;
      target_q      <= RstLvl;
      state_q       <= StIdle;
    end else begin
      sync1_q       <= inc_dec;
      sync2_q       <= sync1_q;
      last_q        <= sync2_q;
      stable_prev_q <= stable_q;
      if (sync2_q != last_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DebLast) begin
        stable_q  <= sync2_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
      tick_q    <= tick_d;
      control_q <= control_d;
      target_q  <= target_d;
      state_q   <= state_d;
    end
  end

  assign control = control_q;
  assign target  = target_q;
  assign ramping = (state_q != StIdle);

endmodule

// File: tb/tb_volume_ramp_ctrl.sv
module tb_volume_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] inc_dec;
  logic       sample_tick;
  logic       mute;
  logic [3:0] control;
  logic [3:0] target;
  logic       ramping;

  int n_chk  = 0;
  int n_fail = 0;
  int tcnt   = 0;

  always #5 clk = ~clk;

  volume_ramp_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MAX_LEVEL      (8),
    .RESET_LEVEL    (0),
    .RAMP_TICKS     (2)
`ifdef VOL_AUTOREPEAT_EN
    ,
    .HOLD_CYCLES    (40),
    .REPEAT_CYCLES  (16)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inc_dec    (inc_dec),
    .sample_tick(sample_tick),
    .mute       (mute),
    .control    (control),
    .target     (target),
    .ramping    (ramping)
  );

  // One sample_tick every 8 clk, driven on the falling edge.
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt + 1) % 8;
      sample_tick = (tcnt == 0);
    end
  end

  typedef struct {
    logic [1:0] code;
    int         exp_target;
    bit         settle;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [1:0] code, input int hold_clk, input int rel_clk);
    @(negedge clk);
    inc_dec = code;
    repeat (hold_clk) @(negedge clk);
    inc_dec = 2'b00;
    repeat (rel_clk) @(negedge clk);
  endtask

  // Returns after the n-th sample_tick edge, outputs already updated.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      @(posedge clk);
      while (!sample_tick && k < 20) begin
        @(posedge clk);
        k++;
      end
      if (k >= 20) chk("tick_timeout", k, 0);
    end
    #1;
  endtask

  task automatic wait_settle();
    int k = 0;
    @(posedge clk);
    #1;
    while (ramping && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("settle_ramping", int'(ramping), 0);
  endtask

  task automatic wait_target(input int exp);
    int k = 0;
    @(posedge clk);
    #1;
    while (int'(target) != exp && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_target", int'(target), exp);
  endtask

  initial begin
    int exp_rep;
    rst     = 1'b1;
    inc_dec = 2'b00;
    mute    = 1'b0;

    // Table: 10 inc presses saturate at 8, then 10 dec presses floor at 0.
    for (int i = 0; i < 10; i++) begin
      vecs[i]      = '{code: 2'b10, exp_target: (i + 2 > 8) ? 8 : i + 2, settle: (i == 9)};
      vecs[i + 10] = '{code: 2'b01, exp_target: (7 - i < 0) ? 0 : 7 - i, settle: (i == 9)};
    end

    // 1. reset state, then idle stability
    repeat (2) @(posedge clk);
    #1;
    chk("rst_control", int'(control), 0);
    chk("rst_target", int'(target), 0);
    chk("rst_ramping", int'(ramping), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_control", int'(control), 0);
    chk("idle_target", int'(target), 0);
    chk("idle_ramping", int'(ramping), 0);

    // 2. single inc press, first step on the 2nd tick
    @(negedge clk);
    inc_dec = 2'b10;
    wait_target(1);
    chk("p1_ramping_hi", int'(ramping), 1);
    chk("p1_control0", int'(control), 0);
    wait_ticks(1);
    chk("p1_tick1_control", int'(control), 0);
    wait_ticks(1);
    chk("p1_tick2_control", int'(control), 1);
    chk("p1_ramping_lo", int'(ramping), 0);
    @(negedge clk);
    inc_dec = 2'b00;
    repeat (12) @(negedge clk);
    chk("p1_target_once", int'(target), 1);

    // 3. glitch and 11 code produce no event
    press(2'b10, 2, 12);
    chk("glitch_target", int'(target), 1);
    press(2'b11, 12, 12);
    chk("code11_target", int'(target), 1);

    // 4. table-driven saturation
    for (int i = 0; i < 20; i++) begin
      press(vecs[i].code, 10, 10);
      chk($sformatf("vec%0d_target", i), int'(target), vecs[i].exp_target);
      if (vecs[i].settle) begin
        wait_settle();
        chk($sformatf("vec%0d_control", i), int'(control), vecs[i].exp_target);
      end
    end

    // 5. soft mute down/up and reversal mid-ramp
    repeat (4) press(2'b10, 10, 10);
    wait_settle();
    chk("m_target4", int'(target), 4);
    chk("m_control4", int'(control), 4);
    @(negedge clk);
    mute = 1'b1;
    for (int v = 3; v >= 0; v--) begin
      wait_ticks(2);
      chk($sformatf("mute_down_%0d", v), int'(control), v);
    end
    chk("mute_target_kept", int'(target), 4);
    @(negedge clk);
    mute = 1'b0;
    wait_ticks(2);
    chk("unmute_1", int'(control), 1);
    wait_ticks(2);
    chk("unmute_2", int'(control), 2);
    @(negedge clk);
    mute = 1'b1;
    wait_ticks(2);
    chk("rev_1", int'(control), 1);
    wait_ticks(2);
    chk("rev_0", int'(control), 0);
    @(negedge clk);
    mute = 1'b0;
    wait_settle();
    chk("unmute_back4", int'(control), 4);

    // 6. reset mid-ramp
    @(negedge clk);
    mute = 1'b1;
    wait_ticks(2);
    chk("pre_rst_control3", int'(control), 3);
    @(negedge clk);
    rst  = 1'b1;
    mute = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_control", int'(control), 0);
    chk("midrst_target", int'(target), 0);
    chk("midrst_ramping", int'(ramping), 0);
    @(negedge clk);
    rst = 1'b0;

    // 7. long hold: auto-repeat only when enabled
`ifdef VOL_AUTOREPEAT_EN
    exp_rep = 5;
`else
    exp_rep = 1;
`endif
    press(2'b10, 100, 15);
    chk("hold100_target", int'(target), exp_rep);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
